irq_controller: RTL and testbench

IRQ_CONTROLLER -- requirements
Module: irq_controller

---
 rtl/irq_controller.sv | 141 ++++++++++++++
 tb/tb_irq_controller.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// -----------------------------------------------------------------------------
// irq_controller
//   Fixed-priority interrupt controller driving a CPU through a
//   CALL -> JUMP -> SERVICE sequence.
//   - Edge channels latch a rising edge into pending until dispatch clears them.
//   - Level channels mirror the registered input.
//   - Masked channels still show as pending but are never selected.
//   - Bit 0 has the highest priority. There is no nesting: a new dispatch can
//     only start after RETI returns the FSM to IDLE.
//
// Ports
//   CLK         clock; all state updates on the rising edge
//   RST         asynchronous active-low reset
//   interrupts  [N_IRQ]  raw interrupt requests
//   irq_mask    [N_IRQ]  1 = channel blocked from dispatch
//   edge_mode   [N_IRQ]  1 = rising-edge latched, 0 = level
//   int_en      global dispatch enable
//   RETI        one-cycle end-of-handler pulse from the core
//   Addr        [ADDR_W] vector address during CALL/JUMP, 0 otherwise
//   Call        core should push its return address
//   INTjmp      core should jump to Addr
//   intSTOP     stall core fetch during the dispatch sequence
//   pending     [N_IRQ]  pending vector, for status readout
// -----------------------------------------------------------------------------
module irq_controller #(
  parameter int                N_IRQ       = 8,
  parameter int                ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] VEC_BASE    = ADDR_W'(16'h00F8),
  parameter int                CALL_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [N_IRQ-1:0]  interrupts,
  input  logic [N_IRQ-1:0]  irq_mask,
  input  logic [N_IRQ-1:0]  edge_mode,
  input  logic              int_en,
  input  logic              RETI,
  output logic [ADDR_W-1:0] Addr,
  output logic              Call,
  output logic              INTjmp,
  output logic              intSTOP,
  output logic [N_IRQ-1:0]  pending
);

  localparam int IDX_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  // CALL lasts CALL_CYCLES cycles; the counter runs 0 .. CALL_CYCLES-1.
  localparam logic [1:0] CNT_LAST = 2'(CALL_CYCLES - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CALL    = 2'd1;
  localparam logic [1:0] S_JUMP    = 2'd2;
  localparam logic [1:0] S_SERVICE = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [1:0]       cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [N_IRQ-1:0] irq_prev;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] clr;
  logic [N_IRQ-1:0] selectable;
  logic [N_IRQ-1:0] pending_nxt;
  logic [IDX_W-1:0] winner;

  assign rise       = interrupts & ~irq_prev;
  assign selectable = pending & ~irq_mask;

  // Fixed priority: scanning from the top down lets the lowest index win.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (selectable[i]) winner = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    case (state)
      S_IDLE: begin
        if (int_en && (|selectable)) begin
          state_nxt = S_CALL;
          idx_nxt   = winner;
          cnt_nxt   = '0;
        end
      end
      S_CALL: begin
        if (cnt == CNT_LAST) state_nxt = S_JUMP;
        else                 cnt_nxt   = cnt + 2'd1;
      end
      S_JUMP:    state_nxt = S_SERVICE;
      S_SERVICE: if (RETI) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // The dispatched channel's edge latch is released as JUMP hands over to
  // SERVICE. The rise term is OR-ed in afterwards, so an edge arriving on
  // that very cycle keeps the bit set.
  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = (state == S_JUMP) && (idx == IDX_W'(i));
    end
    pending_nxt = (edge_mode & ((pending & ~clr) | rise))
                | (~edge_mode & interrupts);
  end

  // Outputs are decoded from the next state and then registered. Each output
  // therefore lines up with the state it describes, and no input reaches an
  // output through combinational logic alone.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      irq_prev <= '0;
      pending  <= '0;
      Call     <= 1'b0;
      INTjmp   <= 1'b0;
      intSTOP  <= 1'b0;
      Addr     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      idx      <= idx_nxt;
      irq_prev <= interrupts;
      pending  <= pending_nxt;
      Call     <= (state_nxt == S_CALL);
      INTjmp   <= (state_nxt == S_JUMP);
      intSTOP  <= (state_nxt == S_CALL) || (state_nxt == S_JUMP);
      Addr     <= ((state_nxt == S_CALL) || (state_nxt == S_JUMP))
                  ? VEC_BASE + ADDR_W'(idx_nxt) : '0;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
// -----------------------------------------------------------------------------
// tb_irq_controller
//   Directed test of irq_controller with a scoreboard. Stimulus code pushes
//   each expected dispatch (vector address and Call length) into a queue.
//   A monitor per DUT checks every cycle on the falling edge:
//     - while Call is high, Addr must equal the expected vector;
//     - when INTjmp is high, one entry is popped and compared;
//     - while idle, intSTOP and Addr must both be 0.
//   DUT a uses the default parameters. DUT b uses N_IRQ=4 and CALL_CYCLES=3.
// -----------------------------------------------------------------------------
module tb_irq_controller;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  logic [7:0]  irq_a = '0, mask_a = '0, emode_a = '0;
  logic        en_a = 1'b0, reti_a = 1'b0;
  logic [15:0] addr_a;
  logic        call_a, jmp_a, stop_a;
  logic [7:0]  pend_a;

  logic [3:0]  irq_b = '0, mask_b = '0, emode_b = '0;
  logic        en_b = 1'b0, reti_b = 1'b0;
  logic [15:0] addr_b;
  logic        call_b, jmp_b, stop_b;
  logic [3:0]  pend_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] addr;
    int          ncall;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  int   run_a = 0;
  int   run_b = 0;

  irq_controller dut_a (
    .CLK(clk), .RST(rst_n), .interrupts(irq_a), .irq_mask(mask_a),
    .edge_mode(emode_a), .int_en(en_a), .RETI(reti_a), .Addr(addr_a),
    .Call(call_a), .INTjmp(jmp_a), .intSTOP(stop_a), .pending(pend_a)
  );

  irq_controller #(.N_IRQ(4), .CALL_CYCLES(3)) dut_b (
    .CLK(clk), .RST(rst_n), .interrupts(irq_b), .irq_mask(mask_b),
    .edge_mode(emode_b), .int_en(en_b), .RETI(reti_b), .Addr(addr_b),
    .Call(call_b), .INTjmp(jmp_b), .intSTOP(stop_b), .pending(pend_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, DUT a
  always @(negedge clk) begin
    if (!rst_n) begin
      run_a = 0;
    end else if (call_a) begin
      run_a++;
      check("a_call_expected", 32'(qa.size() > 0), 1);
      check("a_stop_in_call", 32'(stop_a), 1);
      check("a_jmp_in_call", 32'(jmp_a), 0);
      if (qa.size() > 0) check("a_addr_in_call", 32'(addr_a), 32'(qa[0].addr));
    end else if (jmp_a) begin
      check("a_jmp_expected", 32'(qa.size() > 0), 1);
      check("a_stop_in_jmp", 32'(stop_a), 1);
      if (qa.size() > 0) begin
        exp_t e;
        e = qa.pop_front();
        check("a_addr_in_jmp", 32'(addr_a), 32'(e.addr));
        check("a_call_len", 32'(run_a), 32'(e.ncall));
      end
      run_a = 0;
    end else begin
      check("a_idle_stop", 32'(stop_a), 0);
      check("a_idle_addr", 32'(addr_a), 0);
    end
  end

  // Scoreboard monitor, DUT b
  always @(negedge clk) begin
    if (!rst_n) begin
      run_b = 0;
    end else if (call_b) begin
      run_b++;
      check("b_call_expected", 32'(qb.size() > 0), 1);
      check("b_stop_in_call", 32'(stop_b), 1);
      if (qb.size() > 0) check("b_addr_in_call", 32'(addr_b), 32'(qb[0].addr));
    end else if (jmp_b) begin
      check("b_jmp_expected", 32'(qb.size() > 0), 1);
      if (qb.size() > 0) begin
        exp_t e;
        e = qb.pop_front();
        check("b_addr_in_jmp", 32'(addr_b), 32'(e.addr));
        check("b_call_len", 32'(run_b), 32'(e.ncall));
      end
      run_b = 0;
    end else begin
      check("b_idle_stop", 32'(stop_b), 0);
      check("b_idle_addr", 32'(addr_b), 0);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_call(input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = call_a;
    end
    check({name, "_call_seen"}, 32'(got), 1);
  endtask

  task automatic wait_jmp(input bit sel, input string name);
    bit got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = sel ? jmp_b : jmp_a;
    end
    check({name, "_jmp_seen"}, 32'(got), 1);
  endtask

  task automatic reti_pulse(input bit sel);
    if (sel) reti_b = 1'b1;
    else     reti_a = 1'b1;
    @(negedge clk);
    reti_a = 1'b0;
    reti_b = 1'b0;
  endtask

  initial begin
    // Reset state
    tick(2);
    check("rst_call", 32'(call_a), 0);
    check("rst_jmp", 32'(jmp_a), 0);
    check("rst_stop", 32'(stop_a), 0);
    check("rst_addr", 32'(addr_a), 0);
    check("rst_pend", 32'(pend_a), 0);
    check("rst_pend_b", 32'(pend_b), 0);
    rst_n = 1'b1;
    tick(2);

    // Edge ch3: latency, Call x2, INTjmp x1, Addr 00FB, pending cleared
    emode_a = 8'hFF;
    en_a    = 1'b1;
    qa.push_back('{16'h00FB, 2});
    irq_a[3] = 1'b1;
    tick(1);
    check("t1_pend_latency", 32'(pend_a), 32'h08);
    check("t1_call_not_yet", 32'(call_a), 0);
    tick(1);
    check("t1_call_start", 32'(call_a), 1);
    reti_a = 1'b1;            // must be ignored outside SERVICE
    tick(1);
    reti_a = 1'b0;
    wait_jmp(0, "t1");
    tick(1);
    check("t1_pend_cleared", 32'(pend_a), 0);
    irq_a = '0;
    reti_pulse(0);

    // Simultaneous ch2 and ch6: ch2 first, ch6 after RETI; changes in CALL are ignored
    qa.push_back('{16'h00FA, 2});
    qa.push_back('{16'h00FE, 2});
    irq_a = 8'h44;
    wait_jmp(0, "t2a");
    tick(1);
    irq_a = '0;
    check("t2_ch6_still_pending", 32'(pend_a), 32'h40);
    reti_pulse(0);
    wait_call("t2b");
    en_a   = 1'b0;
    mask_a = 8'hFF;
    wait_jmp(0, "t2b");
    tick(1);
    en_a   = 1'b1;
    mask_a = '0;
    check("t2_pend_empty", 32'(pend_a), 0);
    reti_pulse(0);

    // Masked ch0 pending; ch5 dispatched; then unmasked ch0 dispatched
    mask_a = 8'h01;
    irq_a  = 8'h01;
    tick(1);
    irq_a = '0;
    tick(3);
    check("t3_masked_pending", 32'(pend_a), 32'h01);
    qa.push_back('{16'h00FD, 2});
    irq_a = 8'h20;
    wait_jmp(0, "t3a");
    tick(1);
    irq_a = '0;
    check("t3_after_ch5", 32'(pend_a), 32'h01);
    qa.push_back('{16'h00F8, 2});
    mask_a = '0;
    tick(2);                  // still in SERVICE: no nesting
    reti_pulse(0);
    wait_jmp(0, "t3b");
    tick(1);
    check("t3_pend_empty", 32'(pend_a), 0);
    reti_pulse(0);

    // Level ch1: repeated dispatch while high, none after the input drops
    emode_a = 8'hFD;
    qa.push_back('{16'h00F9, 2});
    irq_a = 8'h02;
    wait_jmp(0, "t4a");
    tick(1);
    check("t4_level_pending", 32'(pend_a), 32'h02);
    qa.push_back('{16'h00F9, 2});
    reti_pulse(0);
    wait_jmp(0, "t4b");
    tick(1);
    irq_a = '0;
    tick(1);
    check("t4_level_dropped", 32'(pend_a), 0);
    reti_pulse(0);
    tick(6);
    check("t4_no_redispatch", 32'(qa.size()), 0);

    // int_en=0 holds off dispatch of pending ch4
    emode_a = 8'hFF;
    en_a    = 1'b0;
    irq_a   = 8'h10;
    tick(4);
    check("t5_pend_held", 32'(pend_a), 32'h10);
    check("t5_no_call", 32'(call_a), 0);
    qa.push_back('{16'h00FC, 2});
    en_a = 1'b1;
    wait_jmp(0, "t5");
    tick(1);
    irq_a = '0;
    reti_pulse(0);

    // Reset during JUMP: immediate abort; a held input re-registers as an edge
    qa.push_back('{16'h00FB, 2});
    irq_a = 8'h08;
    wait_jmp(0, "t6a");
    #1 rst_n = 1'b0;
    #1;
    check("t6_jmp_abort", 32'(jmp_a), 0);
    check("t6_stop_abort", 32'(stop_a), 0);
    check("t6_addr_abort", 32'(addr_a), 0);
    check("t6_call_abort", 32'(call_a), 0);
    check("t6_pend_abort", 32'(pend_a), 0);
    @(negedge clk);
    qa.push_back('{16'h00FB, 2});
    rst_n = 1'b1;
    wait_jmp(0, "t6b");
    tick(1);
    irq_a = '0;
    reti_pulse(0);

    // DUT b: N_IRQ=4, CALL_CYCLES=3
    emode_b = 4'hF;
    en_b    = 1'b1;
    qb.push_back('{16'h00FA, 3});
    irq_b = 4'h4;
    wait_jmp(1, "b1");
    tick(1);
    irq_b = '0;
    reti_pulse(1);
    qb.push_back('{16'h00F8, 3});
    irq_b = 4'h1;
    wait_jmp(1, "b2");
    tick(1);
    irq_b = '0;
    check("b_pend_empty", 32'(pend_b), 0);
    reti_pulse(1);

    tick(3);
    check("qa_drained", 32'(qa.size()), 0);
    check("qb_drained", 32'(qb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
